// File: rtl/segway_stim_pkg.sv
// Shared types and sizing helpers for the Segway stimulus sequencer.
// Step word layout is {op, idx, arg} with arg in the low bits.
package segway_stim_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP      = 3'd0,
        OP_SET_CH   = 3'd1,
        OP_SET_LEAN = 3'd2,
        OP_SEND_CMD = 3'd3,
        OP_WAIT     = 3'd4,
        OP_END      = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_TX_WAIT,
        ST_WAIT_CNT
    } state_e;

    function automatic int idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int step_w(input int num_ch, input int arg_w);
        return OP_W + idx_w(num_ch) + arg_w;
    endfunction

    function automatic int op_lsb(input int num_ch, input int arg_w);
        return arg_w + idx_w(num_ch);
    endfunction

    function automatic int cnt_w(input int arg_w, input int tx_to);
        int to_w;
        to_w = $clog2(tx_to) + 1;
        return (arg_w > to_w) ? arg_w : to_w;
    endfunction

    // Reserved encodings 6 and 7 behave as NOP.
    function automatic op_e decode_op(input logic [OP_W-1:0] raw);
        return (raw > 3'd5) ? OP_NOP : op_e'(raw);
    endfunction

endpackage

// File: rtl/stim_prog_mem.sv
// Program store for the stimulus sequencer: clears to NOP on reset,
// one write port and a registered read port.
module stim_prog_mem
    import segway_stim_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int STEP_W = 30,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [STEP_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [STEP_W-1:0] rdata
);

    logic [STEP_W-1:0] nop_word;
    logic [STEP_W-1:0] mem_q [DEPTH];
    logic [STEP_W-1:0] mem_d [DEPTH];
    logic [STEP_W-1:0] rdata_q;
    logic [STEP_W-1:0] rdata_d;

    always_comb begin
        nop_word = '0;
        nop_word[STEP_W-1 -: OP_W] = OP_NOP;
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= nop_word;
            end
            rdata_q <= nop_word;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/segway_stim_sequencer.sv
// Segway scenario player: steps a loaded program to drive rider lean,
// A2D channel stimulus and UART command bytes.
module segway_stim_sequencer
    import segway_stim_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CH_W   = 12,
    parameter  int LEAN_W = 16,
    parameter  int DEPTH  = 16,
    parameter  int ARG_W  = 24,
    parameter  int TX_TO  = 2**20,
    localparam int PC_W   = $clog2(DEPTH),
    localparam int IDX_W  = idx_w(NUM_CH),
    localparam int STEP_W = step_w(NUM_CH, ARG_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [PC_W-1:0]          prog_addr,
    input  logic [STEP_W-1:0]        prog_data,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_en,
    input  logic                     tx_done,
    output logic                     trmt,
    output logic [7:0]               tx_data,
    output logic signed [LEAN_W-1:0] rider_lean,
    output logic [NUM_CH*CH_W-1:0]   ch_val,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [PC_W-1:0]          pc
);

    localparam int CNT_W  = cnt_w(ARG_W, TX_TO);
    localparam int OP_LSB = op_lsb(NUM_CH, ARG_W);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(DEPTH - 1);

    state_e                     state_q, state_d;
    logic [PC_W-1:0]            pc_q, pc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       trmt_q, trmt_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic signed [LEAN_W-1:0]   lean_q, lean_d;
    logic [NUM_CH*CH_W-1:0]     ch_q, ch_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       tx_prev_q, tx_prev_d;

    logic [STEP_W-1:0]          step;
    op_e                        op;
    logic [IDX_W-1:0]           idx;
    logic [ARG_W-1:0]           arg;
    logic                       mem_we;
    logic                       tx_rise;
    logic                       advance;
    logic                       finish;

    // Program writes are only accepted while no run is in progress.
    assign mem_we = prog_we & ~busy_q;

    stim_prog_mem #(
        .DEPTH  (DEPTH),
        .STEP_W (STEP_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (step)
    );

    assign op      = decode_op(step[OP_LSB +: OP_W]);
    assign idx     = step[ARG_W +: IDX_W];
    assign arg     = step[ARG_W-1:0];
    assign tx_rise = tx_done & ~tx_prev_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        trmt_d    = 1'b0;
        tx_data_d = tx_data_q;
        lean_d    = lean_q;
        ch_d      = ch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tx_prev_d = tx_done;
        advance   = 1'b0;
        finish    = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    unique case (op)
                        OP_SET_CH: begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (int'(idx) == k) begin
                                    ch_d[k*CH_W +: CH_W] = arg[CH_W-1:0];
                                end
                            end
                            advance = 1'b1;
                        end
                        OP_SET_LEAN: begin
                            lean_d  = arg[LEAN_W-1:0];
                            advance = 1'b1;
                        end
                        OP_SEND_CMD: begin
                            tx_data_d = arg[7:0];
                            trmt_d    = 1'b1;
                            cnt_d     = '0;
                            state_d   = ST_TX_WAIT;
                        end
                        OP_WAIT: begin
                            if (arg == '0) begin
                                advance = 1'b1;
                            end else begin
                                cnt_d   = CNT_W'(arg);
                                state_d = ST_WAIT_CNT;
                            end
                        end
                        OP_END: begin
                            finish = 1'b1;
                        end
                        default: begin
                            advance = 1'b1;
                        end
                    endcase
                end
                ST_TX_WAIT: begin
                    if (tx_rise) begin
                        advance = 1'b1;
                    end else if (cnt_q == TX_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_CNT: begin
                    if (cnt_q == CNT_ONE) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // Completing the last slot counts as an implicit END.
        if (advance && (pc_q != PC_LAST)) begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_FETCH;
        end else if (advance || finish) begin
            pc_d = '0;
            if (loop_en) begin
                state_d = ST_FETCH;
            end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            trmt_q    <= 1'b0;
            tx_data_q <= '0;
            lean_q    <= '0;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tx_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            trmt_q    <= trmt_d;
            tx_data_q <= tx_data_d;
            lean_q    <= lean_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_prev_q <= tx_prev_d;
        end
    end

    assign trmt       = trmt_q;
    assign tx_data    = tx_data_q;
    assign rider_lean = lean_q;
    assign ch_val     = ch_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_segway_stim_sequencer.sv
// Self-checking bench for segway_stim_sequencer: single-step vector table,
// hand-written multi-cycle sequences and a UART byte scoreboard.
module tb_segway_stim_sequencer;
    import segway_stim_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 12;
    localparam int LEAN_W = 16;
    localparam int DEPTH  = 16;
    localparam int ARG_W  = 24;
    localparam int TX_TO  = 64;
    localparam int PC_W   = $clog2(DEPTH);
    localparam int IDX_W  = idx_w(NUM_CH);
    localparam int STEP_W = step_w(NUM_CH, ARG_W);

    logic                     clk;
    logic                     rst;
    logic                     prog_we;
    logic [PC_W-1:0]          prog_addr;
    logic [STEP_W-1:0]        prog_data;
    logic                     start;
    logic                     abort;
    logic                     loop_en;
    logic                     tx_done;
    logic                     trmt;
    logic [7:0]               tx_data;
    logic signed [LEAN_W-1:0] rider_lean;
    logic [NUM_CH*CH_W-1:0]   ch_val;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [PC_W-1:0]          pc;

    wire [LEAN_W-1:0] lean_u = rider_lean;

    segway_stim_sequencer #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .LEAN_W (LEAN_W),
        .DEPTH  (DEPTH),
        .ARG_W  (ARG_W),
        .TX_TO  (TX_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .abort      (abort),
        .loop_en    (loop_en),
        .tx_done    (tx_done),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .rider_lean (rider_lean),
        .ch_val     (ch_val),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int trmt_cnt     = 0;
    int done_cnt     = 0;
    int lean_changes = 0;
    bit lean_mon     = 1'b0;
    logic             trmt_prev = 1'b0;
    logic [LEAN_W-1:0] lean_prev = '0;
    logic [7:0]        tx_exp_q[$];
    logic [LEAN_W-1:0] lean_exp_q[$];

    typedef struct {
        int                     op;
        int                     idx;
        int                     arg;
        logic [NUM_CH*CH_W-1:0] exp_ch;
        logic [LEAN_W-1:0]      exp_lean;
        int                     exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [STEP_W-1:0] mk(input int op, input int idx,
                                             input int arg);
        logic [STEP_W-1:0] w;
        w = '0;
        w[STEP_W-1 -: OP_W] = OP_W'(op);
        w[ARG_W +: IDX_W]   = IDX_W'(idx);
        w[ARG_W-1:0]        = ARG_W'(arg);
        return w;
    endfunction

    function automatic logic [CH_W-1:0] chv(input int k);
        return ch_val[k*CH_W +: CH_W];
    endfunction

    task automatic write_step(input int addr, input logic [STEP_W-1:0] w);
        prog_we   = 1'b1;
        prog_addr = PC_W'(addr);
        prog_data = w;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic start_with_write(input int addr, input logic [STEP_W-1:0] w);
        prog_we   = 1'b1;
        prog_addr = PC_W'(addr);
        prog_data = w;
        start     = 1'b1;
        tick();
        prog_we   = 1'b0;
        start     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_trmt(input int limit, output int n);
        n = 0;
        while (trmt !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Monitor on the falling edge: UART byte scoreboard and lean sequence.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (trmt === 1'b1) begin
                trmt_cnt++;
                if (tx_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got trmt with 0x%0h, none queued",
                             tx_data);
                end else begin
                    check("tx_data", tx_data, tx_exp_q.pop_front());
                end
                check("trmt_single_cycle", trmt_prev, 1'b0);
            end
            trmt_prev = trmt;
            if (lean_mon && lean_u != lean_prev) begin
                lean_changes++;
                if (lean_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL loop_lean: got 0x%0h, none queued", lean_u);
                end else begin
                    check("loop_lean", lean_u, lean_exp_q.pop_front());
                end
            end
            lean_prev = lean_u;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int d0;
        int l0;

        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        abort     = 1'b0;
        loop_en   = 1'b0;
        tx_done   = 1'b0;

        vecs[0] = '{1, 0, 'h123,    48'h000_000_000_123, 16'h0000, 4};
        vecs[1] = '{1, 3, 'hABC,    48'hABC_000_000_123, 16'h0000, 4};
        vecs[2] = '{2, 0, 'h8001,   48'hABC_000_000_123, 16'h8001, 4};
        vecs[3] = '{4, 0, 0,        48'hABC_000_000_123, 16'h8001, 4};
        vecs[4] = '{4, 0, 1,        48'hABC_000_000_123, 16'h8001, 5};
        vecs[5] = '{4, 0, 5,        48'hABC_000_000_123, 16'h8001, 9};
        vecs[6] = '{6, 1, 'h777,    48'hABC_000_000_123, 16'h8001, 4};
        vecs[7] = '{1, 2, 'hFFF5A5, 48'hABC_5A5_000_123, 16'h8001, 4};
        vecs[8] = '{7, 0, 'hFFFF,   48'hABC_5A5_000_123, 16'h8001, 4};
        vecs[9] = '{2, 0, 'h12345,  48'hABC_5A5_000_123, 16'h2345, 4};

        tick(2);
        rst = 1'b0;

        check("reset trmt", trmt, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset pc", pc, 0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset lean", lean_u, 16'h0000);
        check("reset ch_val", ch_val, 48'h0);

        // Single step followed by END; step 0 written in the start cycle.
        for (int i = 0; i < 10; i++) begin
            write_step(1, mk(OP_END, 0, 0));
            start_with_write(0, mk(vecs[i].op, vecs[i].idx, vecs[i].arg));
            wait_done(100, n);
            check($sformatf("vec%0d cycles", i), n, vecs[i].exp_cyc);
            check($sformatf("vec%0d ch_val", i), ch_val, vecs[i].exp_ch);
            check($sformatf("vec%0d lean", i), lean_u, vecs[i].exp_lean);
            check($sformatf("vec%0d busy", i), busy, 1'b0);
            check($sformatf("vec%0d pc", i), pc, 0);
            tick();
            check($sformatf("vec%0d done pulse", i), done, 1'b0);
        end

        // Basic scenario with a leftover high tx_done at the start.
        do_reset();
        tx_done = 1'b1;
        write_step(0, mk(OP_SEND_CMD, 0, 'h47));
        write_step(1, mk(OP_SET_CH, 0, 'h300));
        write_step(2, mk(OP_SET_CH, 1, 'h300));
        write_step(3, mk(OP_WAIT, 0, 10));
        write_step(4, mk(OP_SET_LEAN, 0, 'h0FFF));
        write_step(5, mk(OP_END, 0, 0));
        tx_exp_q.push_back(8'h47);
        t0 = trmt_cnt;
        pulse_start();
        check("basic busy", busy, 1'b1);
        wait_trmt(20, n);
        check("basic trmt latency", n, 2);
        tick(3);
        check("basic level tx_done ignored", chv(0), 12'h000);
        check("basic still busy", busy, 1'b1);
        tx_done = 1'b0;
        tick(4);
        tx_done = 1'b1;
        n = 0;
        while (chv(1) != 12'h300 && n < 40) begin
            tick();
            n++;
        end
        check("basic ch1", chv(1), 12'h300);
        check("basic ch0", chv(0), 12'h300);
        n = 0;
        while (lean_u != 16'h0FFF && n < 40) begin
            tick();
            n++;
        end
        check("basic lean delay", n, (10 + 2) + 2);
        wait_done(10, n);
        check("basic done delay", n, 2);
        check("basic busy end", busy, 1'b0);
        tick();
        check("basic done width", done, 1'b0);
        check("basic trmt count", trmt_cnt - t0, 1);

        // All-NOP program: implicit END after the last slot.
        do_reset();
        pulse_start();
        wait_done(100, n);
        check("nop run cycles", n, 2 * DEPTH);
        check("nop run pc", pc, 0);

        // Loop mode.
        do_reset();
        write_step(0, mk(OP_SET_LEAN, 0, 5));
        write_step(1, mk(OP_SET_LEAN, 0, -5));
        write_step(2, mk(OP_END, 0, 0));
        lean_exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            lean_exp_q.push_back((i % 2 == 0) ? 16'h0005 : 16'hFFFB);
        end
        loop_en  = 1'b1;
        lean_mon = 1'b1;
        d0 = done_cnt;
        l0 = lean_changes;
        pulse_start();
        tick(60);
        check("loop no done", done_cnt - d0, 0);
        check("loop lean changes", lean_changes - l0, 20);
        loop_en = 1'b0;
        wait_done(20, n);
        check("loop exit delay", n, 6);
        check("loop exit lean", lean_u, 16'hFFFB);
        check("loop exit busy", busy, 1'b0);
        tick();
        lean_mon = 1'b0;

        // TX timeout, then a new start clears err.
        do_reset();
        tx_done = 1'b0;
        write_step(0, mk(OP_SEND_CMD, 0, 'h55));
        write_step(1, mk(OP_END, 0, 0));
        tx_exp_q.push_back(8'h55);
        d0 = done_cnt;
        pulse_start();
        wait_trmt(20, n);
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("timeout cycles", n, TX_TO);
        check("timeout busy", busy, 1'b0);
        tick(2);
        check("timeout no done", done_cnt - d0, 0);
        check("timeout err sticky", err, 1'b1);
        start_with_write(0, mk(OP_END, 0, 0));
        check("restart clears err", err, 1'b0);
        wait_done(10, n);
        check("restart done", n, 2);

        // Abort during a long WAIT.
        do_reset();
        write_step(0, mk(OP_SET_CH, 2, 'h0AA));
        write_step(1, mk(OP_WAIT, 0, 1000));
        write_step(2, mk(OP_END, 0, 0));
        d0 = done_cnt;
        pulse_start();
        tick(20);
        check("abort pre busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort pc held", pc, 1);
        check("abort ch held", chv(2), 12'h0AA);
        tick(5);
        check("abort stays idle", busy, 1'b0);
        check("abort no done", done_cnt - d0, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort beats start", busy, 1'b0);

        // Writes and starts while busy are dropped.
        do_reset();
        write_step(0, mk(OP_WAIT, 0, 50));
        write_step(1, mk(OP_END, 0, 0));
        pulse_start();
        tick(5);
        write_step(0, mk(OP_SET_CH, 0, 'h111));
        tick(3);
        pulse_start();
        wait_done(100, n);
        check("guard run cycles", n + 10, 54);
        tick();
        pulse_start();
        wait_done(100, n);
        check("guard rerun cycles", n, 54);
        check("guard mem unchanged", chv(0), 12'h000);

        // Reset in the middle of a run.
        tx_done = 1'b0;
        write_step(0, mk(OP_SET_CH, 1, 'h3C3));
        write_step(1, mk(OP_SET_LEAN, 0, 'h100));
        write_step(2, mk(OP_SEND_CMD, 0, 'h99));
        write_step(3, mk(OP_END, 0, 0));
        tx_exp_q.push_back(8'h99);
        pulse_start();
        wait_trmt(20, n);
        check("midrst pre ch1", chv(1), 12'h3C3);
        check("midrst pre lean", lean_u, 16'h0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst ch_val", ch_val, 48'h0);
        check("midrst lean", lean_u, 16'h0000);
        check("midrst tx_data", tx_data, 8'h00);
        check("midrst trmt", trmt, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst pc", pc, 0);
        pulse_start();
        wait_done(100, n);
        check("midrst program cleared", n, 2 * DEPTH);
        check("midrst ch after run", ch_val, 48'h0);

        tick(2);
        check("scoreboard drained", tx_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
